id_hazard_scoreboard: RTL and testbench
=======================================

ID_HAZARD_SCOREBOARD -- requirements
Module: id_hazard_scoreboard

Interface
REQ-001 Parameter NUM_RD_PORTS, default 2: number of ID-stage register read ports checked per cycle.
REQ-002 Parameter PIPE_DEPTH, default 3: number of tracked downstream stages (1=EX, 2=MEM, 3=WB); legal range 2..6.
REQ-003 Parameter LOAD_LAT, default 2: first stage index at which load data is forwardable; legal range 1..PIPE_DEPTH.
REQ-004 Parameter SEL_W, default clog2(PIPE_DEPTH+1): width of each forward-select field.
REQ-005 Clock  input  1  single rising-edge clock for all state.
REQ-006 Reset  input  1  asynchronous, active-high; clears all state.
REQ-007 RdValid  input  NUM_RD_PORTS  per-port "this source register is actually read".
REQ-008 RdAddr  input  5*NUM_RD_PORTS  per-port source register address, port p at bits [5p+4:5p].
REQ-009 IssueValid  input  1  ID holds a valid instruction this cycle.
REQ-010 IssueRegWrite  input  1  ID instruction writes a register.
REQ-011 IssueMemRead  input  1  ID instruction is a load.
REQ-012 IssueDest  input  5  ID instruction destination register.
REQ-013 BranchTaken  input  1  branch/jump resolved taken in ID this cycle.
REQ-014 FwSel  output  SEL_W*NUM_RD_PORTS  per-port source: 0=register file, k=stage k.
REQ-015 PCWriteEnable, IFIDWriteEnable  output  1 each  fetch/IF-ID advance enables.
REQ-016 IDEXFlush  output  1  insert bubble into ID/EX.
REQ-017 IFIDFlush  output  1  squash IF/ID.
REQ-018 StallActive  output  1  FSM in STALL state.
REQ-019 StallCount  output  16  saturating count of stall cycles since reset.

Function
REQ-020 Scoreboard SHALL be PIPE_DEPTH entries {valid, dest, isLoad}; every clock entry k moves to k+1, entry PIPE_DEPTH retires.
REQ-021 Entry 1 SHALL load {IssueValid&IssueRegWrite&(IssueDest!=0), IssueDest, IssueMemRead} when not stalling, else a bubble (valid=0).
REQ-022 For each port with RdValid=1 and RdAddr!=0, the lowest-index (youngest) valid matching entry k SHALL be the hit; no hit gives FwSel=0; RdValid=0 or RdAddr=0 gives FwSel=0.
REQ-023 A hit on a load entry with k<LOAD_LAT SHALL raise a hazard for that port; otherwise FwSel=k.
REQ-024 Stall (combinational) = IssueValid & any port hazard; during stall FwSel values are don't-care but SHALL be 0.
REQ-025 Stall=1 SHALL drive PCWriteEnable=0, IFIDWriteEnable=0, IDEXFlush=1, IFIDFlush=0 in the same cycle.
REQ-026 Stall=0 SHALL drive PCWriteEnable=1, IFIDWriteEnable=1, IDEXFlush=0, IFIDFlush=BranchTaken.
REQ-027 BranchTaken coincident with stall SHALL be ignored (branch re-resolves after the stall with forwarded operands).
REQ-028 FSM states RUN, STALL: RUN->STALL when Stall=1 at clock; STALL->RUN when Stall=0 at clock; StallActive=1 in STALL.
REQ-029 StallCount SHALL increment on every clock where Stall=1, saturating at 16'hFFFF.
REQ-030 Maximum consecutive stall cycles for one instruction SHALL be LOAD_LAT-1.

Reset
REQ-031 Reset SHALL clear all entry valid bits, set FSM to RUN, StallCount to 0.
REQ-032 Outputs while Reset=1: FwSel=0, PCWriteEnable=1, IFIDWriteEnable=1, IDEXFlush=0, IFIDFlush=0, StallActive=0.
REQ-033 Reset asserted mid-stall SHALL drop all hazards immediately (asynchronous); first cycle after release behaves as empty scoreboard.

Structure
REQ-034 Shared package holds the FSM state encoding (RUN=0, STALL=1) and the forward-select constant FW_RF=0.
REQ-035 One sub-module, hazard_port_match, SHALL implement the per-port priority search (REQ-022/023), instantiated NUM_RD_PORTS times.

Verification
REQ-036 Defaults; issue lw dest=8, next cycle read port0=8 -> one stall cycle (PCWriteEnable=0, IDEXFlush=1), then FwSel[0]=2, StallCount=1.
REQ-037 Issue add dest=5, next cycle port1 reads 5 -> no stall, FwSel[1]=1; following cycle FwSel[1]=2, then 3, then 0.
REQ-038 Two writers to reg 9 in stages 1 and 2, port0 reads 9 -> FwSel[0]=1 (youngest wins).
REQ-039 RdAddr=0 with a pending writer to 0, or RdValid=0 on a matching address -> FwSel=0, no stall.
REQ-040 Load-use stall with BranchTaken=1 -> IFIDFlush=0 during stall, IFIDFlush=1 next cycle with BranchTaken held.
REQ-041 PIPE_DEPTH=5, LOAD_LAT=4: lw then dependent read -> 3 stall cycles, then FwSel=4; Reset pulsed during cycle 2 -> stall drops, StallCount=0.

Source files
------------

// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared types for the ID-stage hazard scoreboard: FSM encoding, forward-select
// constants and the per-stage scoreboard entry.
package id_hazard_scoreboard_pkg;

    localparam int REG_AW = 5;
    localparam int FW_RF  = 0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } stall_state_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              is_load;
    } sb_entry_t;

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// ID-stage request/response bundle between the decode stage (master) and the
// hazard scoreboard (slave).
interface id_hazard_scoreboard_if #(
    parameter int NUM_RD_PORTS = 2,
    parameter int SEL_W        = 2
);
    import id_hazard_scoreboard_pkg::*;

    logic [NUM_RD_PORTS-1:0]             rd_valid;
    logic [NUM_RD_PORTS-1:0][REG_AW-1:0] rd_addr;
    logic                                issue_valid;
    logic                                issue_reg_write;
    logic                                issue_mem_read;
    logic [REG_AW-1:0]                   issue_dest;
    logic                                branch_taken;

    logic [NUM_RD_PORTS-1:0][SEL_W-1:0]  fw_sel;
    logic                                pc_write_enable;
    logic                                if_id_write_enable;
    logic                                id_ex_flush;
    logic                                if_id_flush;
    logic                                stall_active;
    logic [15:0]                         stall_count;

    modport master (
        output rd_valid, rd_addr, issue_valid, issue_reg_write, issue_mem_read,
               issue_dest, branch_taken,
        input  fw_sel, pc_write_enable, if_id_write_enable, id_ex_flush,
               if_id_flush, stall_active, stall_count
    );

    modport slave (
        input  rd_valid, rd_addr, issue_valid, issue_reg_write, issue_mem_read,
               issue_dest, branch_taken,
        output fw_sel, pc_write_enable, if_id_write_enable, id_ex_flush,
               if_id_flush, stall_active, stall_count
    );

endinterface

// File: rtl/id_hazard_scoreboard_port_match.sv
// Per-read-port priority search over the scoreboard: youngest matching writer
// wins; a load too young to forward turns the hit into a hazard.
module hazard_port_match
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter int LOAD_LAT   = 2,
    parameter int SEL_W      = 2
) (
    input  logic                         rd_valid,
    input  logic [REG_AW-1:0]            rd_addr,
    input  sb_entry_t [PIPE_DEPTH:1]     sb,
    output logic [SEL_W-1:0]             fw_sel,
    output logic                         hazard
);

    int   hit_k;
    logic hit_load;

    always_comb begin
        hit_k    = 0;
        hit_load = 1'b0;
        // Walk oldest to youngest so the youngest match overwrites the rest.
        if (rd_valid && (rd_addr != '0)) begin
            for (int k = PIPE_DEPTH; k >= 1; k--) begin
                if (sb[k].valid && (sb[k].dest == rd_addr)) begin
                    hit_k    = k;
                    hit_load = sb[k].is_load;
                end
            end
        end
        hazard = (hit_k != 0) && hit_load && (hit_k < LOAD_LAT);
        fw_sel = hazard ? SEL_W'(FW_RF) : SEL_W'(hit_k);
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight writers, picks forwarding
// sources per read port and stalls on load-use hazards.
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int NUM_RD_PORTS = 2,
    parameter int PIPE_DEPTH   = 3,
    parameter int LOAD_LAT     = 2,
    parameter int SEL_W        = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    id_hazard_scoreboard_if.slave bus
);

    sb_entry_t [PIPE_DEPTH:1]           sb_q;
    logic [NUM_RD_PORTS-1:0]            port_hazard;
    logic [NUM_RD_PORTS-1:0][SEL_W-1:0] port_sel;
    logic                               stall;
    stall_state_e                       state_q, state_d;
    logic [15:0]                        stall_count_q;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        hazard_port_match #(
            .PIPE_DEPTH (PIPE_DEPTH),
            .LOAD_LAT   (LOAD_LAT),
            .SEL_W      (SEL_W)
        ) u_match (
            .rd_valid (bus.rd_valid[p]),
            .rd_addr  (bus.rd_addr[p]),
            .sb       (sb_q),
            .fw_sel   (port_sel[p]),
            .hazard   (port_hazard[p])
        );
    end

    assign stall = bus.issue_valid & (|port_hazard) & ~rst;

    // A stalled instruction stays in ID, so stage 1 receives a bubble while
    // older entries keep draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            if (stall) begin
                sb_q[1] <= '0;
            end else begin
                sb_q[1].valid   <= bus.issue_valid & bus.issue_reg_write & (bus.issue_dest != '0);
                sb_q[1].dest    <= bus.issue_dest;
                sb_q[1].is_load <= bus.issue_mem_read;
            end
            for (int k = 2; k <= PIPE_DEPTH; k++) begin
                sb_q[k] <= sb_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (stall)  state_d = ST_STALL;
            ST_STALL: if (!stall) state_d = ST_RUN;
            default:              state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_count_q <= '0;
        else if (stall && (stall_count_q != 16'hFFFF)) stall_count_q <= stall_count_q + 16'd1;
    end

    // Branch resolved under a stall is dropped; it re-resolves once operands forward.
    assign bus.fw_sel             = (stall || rst) ? '0 : port_sel;
    assign bus.pc_write_enable    = ~stall;
    assign bus.if_id_write_enable = ~stall;
    assign bus.id_ex_flush        = stall;
    assign bus.if_id_flush        = bus.branch_taken & ~stall & ~rst;
    assign bus.stall_active       = (state_q == ST_STALL);
    assign bus.stall_count        = stall_count_q;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Bench for id_hazard_scoreboard: default config (depth 3, lat 2) and a deep
// config (depth 5, lat 4) share one stimulus stream.
module tb_id_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]      rv;
    logic [1:0][4:0] ra;
    logic            iv, irw, imr, bt;
    logic [4:0]      idst;

    int total = 0;
    int bad   = 0;

    id_hazard_scoreboard_if #(.NUM_RD_PORTS(2), .SEL_W(2)) if0 ();
    id_hazard_scoreboard_if #(.NUM_RD_PORTS(2), .SEL_W(3)) if1 ();

    id_hazard_scoreboard u0 (.clk(clk), .rst(rst), .bus(if0));
    id_hazard_scoreboard #(.PIPE_DEPTH(5), .LOAD_LAT(4)) u1 (.clk(clk), .rst(rst), .bus(if1));

    assign if0.rd_valid = rv;        assign if1.rd_valid = rv;
    assign if0.rd_addr = ra;         assign if1.rd_addr = ra;
    assign if0.issue_valid = iv;     assign if1.issue_valid = iv;
    assign if0.issue_reg_write = irw; assign if1.issue_reg_write = irw;
    assign if0.issue_mem_read = imr; assign if1.issue_mem_read = imr;
    assign if0.issue_dest = idst;    assign if1.issue_dest = idst;
    assign if0.branch_taken = bt;    assign if1.branch_taken = bt;

    // ctl = {pc_we, ifid_we, idex_flush, ifid_flush, stall_active}
    logic [1:0][2:0] o_fw  [2];
    logic [4:0]      o_ctl [2];
    logic [15:0]     o_cnt [2];
    assign o_fw[0]  = {1'b0, if0.fw_sel[1], 1'b0, if0.fw_sel[0]};
    assign o_fw[1]  = {if1.fw_sel[1], if1.fw_sel[0]};
    assign o_ctl[0] = {if0.pc_write_enable, if0.if_id_write_enable, if0.id_ex_flush, if0.if_id_flush, if0.stall_active};
    assign o_ctl[1] = {if1.pc_write_enable, if1.if_id_write_enable, if1.id_ex_flush, if1.if_id_flush, if1.stall_active};
    assign o_cnt[0] = if0.stall_count;
    assign o_cnt[1] = if1.stall_count;

    localparam logic [4:0] CTL_RUN   = 5'b11000;
    localparam logic [4:0] CTL_STL1  = 5'b00100;
    localparam logic [4:0] CTL_STLN  = 5'b00101;
    localparam logic [4:0] CTL_AFTER = 5'b11001;

    // Reference model: every issued writer with the cycle it left ID; its
    // stage at cycle t is simply t - issue_cycle.
    typedef struct {
        int       cfg;
        int       cyc;
        logic [4:0] dest;
        bit       ld;
    } rec_t;
    rec_t hist[$];
    int   depth_c[2] = '{3, 5};
    int   lat_c[2]   = '{2, 4};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input bit v, input bit w, input bit m, input logic [4:0] d,
                         input logic [1:0] r, input logic [4:0] a0, input logic [4:0] a1, input bit b);
        iv = v; irw = w; imr = m; idst = d; rv = r; ra[0] = a0; ra[1] = a1; bt = b;
    endtask

    task automatic flush();
        drive(0, 0, 0, 5'd0, 2'b00, 5'd0, 5'd0, 0);
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 1, 5'd8, 2'b11, 5'd8, 5'd8, 1);
        tick();
        for (int c = 0; c < 2; c++) begin
            total++; if (o_ctl[c] !== CTL_RUN) begin bad++; $display("FAIL reset_ctl cfg%0d got=%b exp=%b", c, o_ctl[c], CTL_RUN); end
            total++; if (o_fw[c] !== 6'd0) begin bad++; $display("FAIL reset_fw cfg%0d got=%h exp=0", c, o_fw[c]); end
            total++; if (o_cnt[c] !== 16'd0) begin bad++; $display("FAIL reset_cnt cfg%0d got=%0d exp=0", c, o_cnt[c]); end
        end
        rst = 1'b0;
        flush();
    endtask

    task automatic test_load_use();
        logic [15:0] c0;
        flush();
        c0 = o_cnt[0];
        drive(1, 1, 1, 5'd8, 2'b00, 5'd0, 5'd0, 0);
        tick();
        drive(1, 1, 0, 5'd3, 2'b01, 5'd8, 5'd0, 0);
        settle();
        total++; if (o_ctl[0] !== CTL_STL1) begin bad++; $display("FAIL lu_stall_ctl got=%b exp=%b", o_ctl[0], CTL_STL1); end
        total++; if (o_fw[0][0] !== 3'd0) begin bad++; $display("FAIL lu_stall_fw got=%0d exp=0", o_fw[0][0]); end
        tick();
        total++; if (o_ctl[0] !== CTL_AFTER) begin bad++; $display("FAIL lu_after_ctl got=%b exp=%b", o_ctl[0], CTL_AFTER); end
        total++; if (o_fw[0][0] !== 3'd2) begin bad++; $display("FAIL lu_after_fw got=%0d exp=2", o_fw[0][0]); end
        total++; if (o_cnt[0] !== 16'(c0 + 16'd1)) begin bad++; $display("FAIL lu_cnt got=%0d exp=%0d", o_cnt[0], c0 + 16'd1); end
    endtask

    task automatic test_forward_chain();
        flush();
        drive(1, 1, 0, 5'd5, 2'b00, 5'd0, 5'd0, 0);
        tick();
        drive(1, 0, 0, 5'd0, 2'b10, 5'd0, 5'd5, 0);
        for (int k = 1; k <= 4; k++) begin
            if (k == 1) settle(); else tick();
            total++; if (o_fw[0][1] !== 3'(k <= 3 ? k : 0)) begin bad++; $display("FAIL chain_fw cfg0 k=%0d got=%0d exp=%0d", k, o_fw[0][1], (k <= 3 ? k : 0)); end
            total++; if (o_fw[1][1] !== 3'(k)) begin bad++; $display("FAIL chain_fw cfg1 k=%0d got=%0d exp=%0d", k, o_fw[1][1], k); end
            total++; if (o_ctl[0] !== CTL_RUN) begin bad++; $display("FAIL chain_ctl k=%0d got=%b exp=%b", k, o_ctl[0], CTL_RUN); end
        end
    endtask

    task automatic test_youngest();
        flush();
        drive(1, 1, 1, 5'd9, 2'b00, 5'd0, 5'd0, 0);
        tick();
        drive(1, 1, 0, 5'd9, 2'b00, 5'd0, 5'd0, 0);
        tick();
        drive(1, 0, 0, 5'd0, 2'b11, 5'd9, 5'd9, 0);
        settle();
        for (int c = 0; c < 2; c++) begin
            total++; if (o_fw[c] !== {3'd1, 3'd1}) begin bad++; $display("FAIL youngest_fw cfg%0d got=%h exp=%h", c, o_fw[c], {3'd1, 3'd1}); end
            total++; if (o_ctl[c] !== CTL_RUN) begin bad++; $display("FAIL youngest_ctl cfg%0d got=%b exp=%b", c, o_ctl[c], CTL_RUN); end
        end
    endtask

    task automatic test_zero_rdvalid();
        flush();
        drive(1, 1, 1, 5'd0, 2'b00, 5'd0, 5'd0, 0);
        tick();
        drive(1, 1, 1, 5'd7, 2'b00, 5'd0, 5'd0, 0);
        tick();
        drive(1, 0, 0, 5'd0, 2'b01, 5'd0, 5'd7, 0);
        settle();
        for (int c = 0; c < 2; c++) begin
            total++; if (o_fw[c] !== 6'd0) begin bad++; $display("FAIL zero_fw cfg%0d got=%h exp=0", c, o_fw[c]); end
            total++; if (o_ctl[c] !== CTL_RUN) begin bad++; $display("FAIL zero_ctl cfg%0d got=%b exp=%b", c, o_ctl[c], CTL_RUN); end
        end
    endtask

    task automatic test_branch_stall();
        flush();
        drive(1, 1, 1, 5'd8, 2'b00, 5'd0, 5'd0, 0);
        tick();
        drive(1, 1, 0, 5'd3, 2'b01, 5'd8, 5'd0, 1);
        settle();
        total++; if (o_ctl[0] !== CTL_STL1) begin bad++; $display("FAIL br_stall_ctl got=%b exp=%b", o_ctl[0], CTL_STL1); end
        tick();
        total++; if (o_ctl[0] !== 5'b11011) begin bad++; $display("FAIL br_after_ctl got=%b exp=%b", o_ctl[0], 5'b11011); end
        total++; if (o_fw[0][0] !== 3'd2) begin bad++; $display("FAIL br_after_fw got=%0d exp=2", o_fw[0][0]); end
    endtask

    task automatic test_deep();
        logic [15:0] c1;
        flush();
        c1 = o_cnt[1];
        drive(1, 1, 1, 5'd8, 2'b00, 5'd0, 5'd0, 0);
        tick();
        drive(1, 0, 0, 5'd0, 2'b01, 5'd8, 5'd0, 0);
        for (int s = 0; s < 3; s++) begin
            if (s == 0) settle(); else tick();
            total++; if (o_ctl[1] !== (s == 0 ? CTL_STL1 : CTL_STLN)) begin bad++; $display("FAIL deep_stall_ctl s=%0d got=%b", s, o_ctl[1]); end
        end
        tick();
        total++; if (o_ctl[1] !== CTL_AFTER) begin bad++; $display("FAIL deep_after_ctl got=%b exp=%b", o_ctl[1], CTL_AFTER); end
        total++; if (o_fw[1][0] !== 3'd4) begin bad++; $display("FAIL deep_after_fw got=%0d exp=4", o_fw[1][0]); end
        total++; if (o_cnt[1] !== 16'(c1 + 16'd3)) begin bad++; $display("FAIL deep_cnt got=%0d exp=%0d", o_cnt[1], c1 + 16'd3); end

        flush();
        drive(1, 1, 1, 5'd8, 2'b00, 5'd0, 5'd0, 0);
        tick();
        drive(1, 0, 0, 5'd0, 2'b01, 5'd8, 5'd0, 0);
        settle();
        tick();
        total++; if (o_ctl[1] !== CTL_STLN) begin bad++; $display("FAIL deep_rst_pre got=%b exp=%b", o_ctl[1], CTL_STLN); end
        rst = 1'b1;
        settle();
        total++; if (o_ctl[1] !== CTL_RUN) begin bad++; $display("FAIL deep_rst_ctl got=%b exp=%b", o_ctl[1], CTL_RUN); end
        total++; if (o_cnt[1] !== 16'd0) begin bad++; $display("FAIL deep_rst_cnt got=%0d exp=0", o_cnt[1]); end
        tick();
        rst = 1'b0;
        settle();
        total++; if (o_ctl[1] !== CTL_RUN) begin bad++; $display("FAIL deep_post_ctl got=%b exp=%b", o_ctl[1], CTL_RUN); end
        total++; if (o_fw[1] !== 6'd0) begin bad++; $display("FAIL deep_post_fw got=%h exp=0", o_fw[1]); end
    endtask

    task automatic test_random();
        int  cyc;
        int  cnt_m[2];
        bit  st_m[2];
        bit  stall_c[2];
        int  sel[2];
        bit  hz[2];
        int  best_age, age;
        bit  best_ld, stall;
        logic [1:0][2:0] exp_fw;
        logic [4:0]      exp_ctl;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        hist.delete();
        cyc = 0;
        cnt_m = '{0, 0};
        st_m  = '{0, 0};
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
                  5'($urandom_range(0, 4)), 2'($urandom), 5'($urandom_range(0, 4)),
                  5'($urandom_range(0, 4)), 1'($urandom));
            settle();
            for (int c = 0; c < 2; c++) begin
                for (int p = 0; p < 2; p++) begin
                    best_age = 0;
                    best_ld  = 1'b0;
                    if (rv[p] && ra[p] != 5'd0) begin
                        foreach (hist[i]) begin
                            age = cyc - hist[i].cyc;
                            if (hist[i].cfg == c && hist[i].dest == ra[p] && age <= depth_c[c] &&
                                (best_age == 0 || age < best_age)) begin
                                best_age = age;
                                best_ld  = hist[i].ld;
                            end
                        end
                    end
                    hz[p]  = (best_age != 0) && best_ld && (best_age < lat_c[c]);
                    sel[p] = hz[p] ? 0 : best_age;
                end
                stall      = iv && (hz[0] || hz[1]);
                stall_c[c] = stall;
                exp_fw     = stall ? 6'd0 : {3'(sel[1]), 3'(sel[0])};
                exp_ctl    = {!stall, !stall, stall, !stall && bt, st_m[c]};
                total++; if (o_ctl[c] !== exp_ctl) begin bad++; $display("FAIL rnd_ctl cfg%0d n=%0d got=%b exp=%b", c, n, o_ctl[c], exp_ctl); end
                total++; if (o_fw[c] !== exp_fw) begin bad++; $display("FAIL rnd_fw cfg%0d n=%0d got=%h exp=%h", c, n, o_fw[c], exp_fw); end
                total++; if (o_cnt[c] !== 16'(cnt_m[c])) begin bad++; $display("FAIL rnd_cnt cfg%0d n=%0d got=%0d exp=%0d", c, n, o_cnt[c], cnt_m[c]); end
            end
            tick();
            for (int c = 0; c < 2; c++) begin
                st_m[c] = stall_c[c];
                if (stall_c[c] && cnt_m[c] < 65535) cnt_m[c]++;
                if (!stall_c[c] && iv && irw && idst != 5'd0) hist.push_back('{c, cyc, idst, imr});
            end
            cyc++;
            while (hist.size() > 0 && (cyc - hist[0].cyc) > 6) void'(hist.pop_front());
        end
    endtask

    initial begin
        drive(0, 0, 0, 5'd0, 2'b00, 5'd0, 5'd0, 0);
        test_reset();
        test_load_use();
        test_forward_chain();
        test_youngest();
        test_zero_rdvalid();
        test_branch_stall();
        test_deep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
